// File: rtl/controle_pkg.sv
// Shared definitions for the processor control unit: opcodes, FSM states and
// instruction-register field widths.
package controle_pkg;

  localparam int OP_W  = 3;
  localparam int REG_W = 3;
  localparam int IR_W  = OP_W + 2 * REG_W;
  localparam int NREGS = 1 << REG_W;

  localparam logic [OP_W-1:0] MV   = 3'b000;
  localparam logic [OP_W-1:0] MVI  = 3'b001;
  localparam logic [OP_W-1:0] ADD  = 3'b010;
  localparam logic [OP_W-1:0] SUB  = 3'b011;
  localparam logic [OP_W-1:0] MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  // Add and sub are the only opcodes that need the T2/T3 accumulator steps.
  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[w_i] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Control unit for a simple multi-cycle processor (mv, mvi, add, sub).
// Optional mvnz instruction is built when UNIDADE_CONTROLE_MVNZ_EN is defined.
module unidade_controle
  import controle_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [15:0]           Din,
  input  logic                  Gnz,
  output logic [NREGS-1:0]      Rin,
  output logic [NREGS-1:0]      controlReg,
  output logic                  Gout,
  output logic                  Din_out,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  AddSub,
  output logic                  Done,
  output logic [IR_W-1:0]       IR,
  output logic [1:0]            state_dbg_o
);

  state_e                state_q;
  logic [IR_W-1:0]       ir_q;
  logic                  ir_in;

  logic [OP_W-1:0]       op;
  logic [REG_W-1:0]      rx;
  logic [REG_W-1:0]      ry;

  logic                  rin_en;
  logic                  src_en;
  logic [REG_W-1:0]      src_sel;
  logic                  gout_c;
  logic                  din_out_c;
  logic                  ain_c;
  logic                  gin_c;
  logic                  addsub_c;
  logic                  done_c;

  assign op    = ir_q[IR_W-1 -: OP_W];
  assign rx    = ir_q[2*REG_W-1 -: REG_W];
  assign ry    = ir_q[REG_W-1:0];
  assign ir_in = (state_q == T0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        T0: if (ir_in && Run) begin
          ir_q    <= Din[IR_W-1:0];
          state_q <= T1;
        end
        T1:      state_q <= is_alu(op) ? T2 : T0;
        T2:      state_q <= T3;
        T3:      state_q <= T0;
        default: state_q <= T0;
      endcase
    end
  end

  always_comb begin
    rin_en    = 1'b0;
    src_en    = 1'b0;
    src_sel   = ry;
    gout_c    = 1'b0;
    din_out_c = 1'b0;
    ain_c     = 1'b0;
    gin_c     = 1'b0;
    addsub_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      T1: begin
        case (op)
          MV: begin
            src_en = 1'b1;
            rin_en = 1'b1;
            done_c = 1'b1;
          end
          MVI: begin
            din_out_c = 1'b1;
            rin_en    = 1'b1;
            done_c    = 1'b1;
          end
          ADD, SUB: begin
            src_sel = rx;
            src_en  = 1'b1;
            ain_c   = 1'b1;
          end
`ifdef UNIDADE_CONTROLE_MVNZ_EN
          MVNZ: begin
            src_en = Gnz;
            rin_en = Gnz;
            done_c = 1'b1;
          end
`endif
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        src_en   = 1'b1;
        gin_c    = 1'b1;
        addsub_c = op[0];
      end
      T3: begin
        gout_c = 1'b1;
        rin_en = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef UNIDADE_CONTROLE_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = Gnz;
`endif

  logic unused_din_hi;
  assign unused_din_hi = ^Din[15:IR_W];

  // Reset masks every control line in the cycle it is asserted, so an aborted
  // add/sub can never write back through Rin.
  dec3to8 u_dec_rin (
    .w_i  (rx),
    .en_i (rin_en & ~Reset),
    .y_o  (Rin)
  );

  dec3to8 u_dec_src (
    .w_i  (src_sel),
    .en_i (src_en & ~Reset),
    .y_o  (controlReg)
  );

  assign Gout        = gout_c    & ~Reset;
  assign Din_out     = din_out_c & ~Reset;
  assign Ain         = ain_c     & ~Reset;
  assign Gin         = gin_c     & ~Reset;
  assign AddSub      = addsub_c  & ~Reset;
  assign Done        = done_c    & ~Reset;
  assign IR          = Reset ? '0 : ir_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: per-cycle control vectors from a
// reference model are queued at issue and compared as the FSM steps.
module tb_unidade_controle;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] Din;
  logic        Gnz;
  logic [7:0]  Rin;
  logic [7:0]  controlReg;
  logic        Gout;
  logic        Din_out;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [8:0]  IR;
  logic [1:0]  state_dbg_o;

  unidade_controle dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
    .Din         (Din),
    .Gnz         (Gnz),
    .Rin         (Rin),
    .controlReg  (controlReg),
    .Gout        (Gout),
    .Din_out     (Din_out),
    .Ain         (Ain),
    .Gin         (Gin),
    .AddSub      (AddSub),
    .Done        (Done),
    .IR          (IR),
    .state_dbg_o (state_dbg_o)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] exp_q[$];
  logic        prev_done = 1'b0;

  wire [21:0] obs = {Rin, controlReg, Gout, Din_out, Ain, Gin, AddSub, Done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] r);
    logic [7:0] v;
    v = 8'd1;
    return v << r;
  endfunction

  // Reference model: expected {Rin,controlReg,Gout,Din_out,Ain,Gin,AddSub,Done}
  // for every cycle from T1 until the instruction's Done.
  task automatic model(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic gnz);
    case (op)
      3'b000: exp_q.push_back({oh(x), oh(y), 6'b000001});
      3'b001: exp_q.push_back({oh(x), 8'h00, 6'b010001});
      3'b010, 3'b011: begin
        exp_q.push_back({8'h00, oh(x), 6'b001000});
        exp_q.push_back({8'h00, oh(y), 3'b000, 1'b1, op[0], 1'b0});
        exp_q.push_back({oh(x), 8'h00, 6'b100001});
      end
`ifdef UNIDADE_CONTROLE_MVNZ_EN
      3'b100: begin
        if (gnz) exp_q.push_back({oh(x), oh(y), 6'b000001});
        else     exp_q.push_back({16'h0000, 6'b000001});
      end
`endif
      default: exp_q.push_back({16'h0000, 6'b000001});
    endcase
  endtask

  // Driver: issue one instruction from T0 and check every cycle until Done.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                           input logic [15:0] imm, input logic gnz, input logic [6:0] hi);
    logic [15:0] w;
    int n;
    @(negedge Clock);
    check("t0_idle", {10'd0, obs}, 32'd0);
    check("t0_state", {30'd0, state_dbg_o}, 32'd0);
    w   = {hi, op, x, y};
    Din = w;
    Run = 1'b1;
    Gnz = gnz;
    model(op, x, y, gnz);
    n = exp_q.size();
    @(posedge Clock);
    #1;
    Din = imm;
    Run = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (i == 0) check("ir_load", {23'd0, IR}, {23'd0, w[8:0]});
      check("ctl", {10'd0, obs}, {10'd0, exp_q.pop_front()});
      @(posedge Clock);
      #1;
      Run = 1'($urandom_range(0, 1));
    end
  endtask

  // Every-cycle structural rules on the control outputs.
  always @(negedge Clock) begin
    check("src_onehot", {31'd0, ($countones({controlReg, Gout, Din_out}) <= 1)}, 32'd1);
    check("rin_onehot", {31'd0, ($countones(Rin) <= 1)}, 32'd1);
    check("done_pulse", {31'd0, prev_done & Done}, 32'd0);
    if (state_dbg_o == 2'd0) check("t0_quiet", {10'd0, obs}, 32'd0);
    if (state_dbg_o == 2'd2) check("t2_no_rin", {24'd0, Rin}, 32'd0);
    prev_done = Done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    Din   = 16'h0005;
    Gnz   = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      check("rst_outputs", {10'd0, obs}, 32'd0);
      check("rst_ir", {23'd0, IR}, 32'd0);
      check("rst_state", {30'd0, state_dbg_o}, 32'd0);
    end
    Run   = 1'b0;
    Reset = 1'b0;

    // Run low: IR holds and FSM stays in T0.
    repeat (2) begin
      @(negedge Clock);
      check("idle_state", {30'd0, state_dbg_o}, 32'd0);
      check("idle_ir", {23'd0, IR}, 32'd0);
    end

    run_instr(3'b000, 3'd0, 3'd5, 16'h0000, 1'b0, 7'd0);   // 0x0005 mv R0,R5
    run_instr(3'b001, 3'd1, 3'd0, 16'h1234, 1'b0, 7'd0);   // 0x0048 mvi R1
    run_instr(3'b011, 3'd2, 3'd3, 16'h0000, 1'b0, 7'd0);   // 0x00D3 sub R2,R3
    run_instr(3'b010, 3'd3, 3'd3, 16'h0000, 1'b0, 7'd0);   // add R3,R3
    run_instr(3'b000, 3'd3, 3'd3, 16'h0000, 1'b0, 7'd0);   // mv R3,R3
    run_instr(3'b100, 3'd0, 3'd1, 16'h0000, 1'b0, 7'd0);   // 0x0101 Gnz=0
    run_instr(3'b100, 3'd0, 3'd1, 16'h0000, 1'b1, 7'd0);   // 0x0101 Gnz=1
    run_instr(3'b101, 3'd7, 3'd6, 16'h0000, 1'b1, 7'd0);
    run_instr(3'b110, 3'd4, 3'd2, 16'h0000, 1'b0, 7'd0);
    run_instr(3'b111, 3'd5, 3'd5, 16'h0000, 1'b1, 7'h7F);

    // Reset during T2 of an add aborts it with no write-back.
    @(negedge Clock);
    Din = 16'h0093;
    Run = 1'b1;
    @(posedge Clock);
    #1;
    Run = 1'b0;
    @(negedge Clock);
    check("abort_t1", {30'd0, state_dbg_o}, 32'd1);
    @(negedge Clock);
    check("abort_t2", {30'd0, state_dbg_o}, 32'd2);
    Reset = 1'b1;
    Run   = 1'b1;
    #1;
    check("abort_gate", {10'd0, obs}, 32'd0);
    @(negedge Clock);
    check("abort_state", {30'd0, state_dbg_o}, 32'd0);
    check("abort_outputs", {10'd0, obs}, 32'd0);
    check("abort_ir", {23'd0, IR}, 32'd0);
    Reset = 1'b0;
    Run   = 1'b0;
    @(negedge Clock);
    check("abort_after", {10'd0, obs}, 32'd0);

    // Random instruction stream, back-to-back issue.
    for (int k = 0; k < 150; k++) begin
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
    end

    Run = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      check("end_idle", {30'd0, state_dbg_o}, 32'd0);
    end
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Run, input, 1, start request; sampled only in state T0.
REQ-004 SHALL have port Din, input, 16, external data bus; instruction word is Din[8:0], formatted III XXX YYY (op, Rx, Ry).
REQ-005 SHALL have port Gnz, input, 1, G register non-zero flag; used only with MVNZ_EN.
REQ-006 SHALL have port Rin, output, 8, register load enables; bit i loads Ri.
REQ-007 SHALL have port controlReg, output, 8, bus source select for R7..R0; bit i drives Ri onto the bus.
REQ-008 SHALL have ports Gout, Din_out ("Din" select), Ain, Gin, AddSub (1 = subtract), Done, all output, 1.
REQ-009 SHALL have port IR, output, 9, current instruction register.

Function
REQ-010 SHALL implement a 4-state FSM: T0, T1, T2, T3.
REQ-011 T0: IRin asserted internally; if Run=1, IR <= Din[8:0] and next = T1; else stay T0, IR holds.
REQ-012 op 000 mv: T1 asserts controlReg[Y], Rin[X], Done; next T0.
REQ-013 op 001 mvi: T1 asserts Din_out, Rin[X], Done; immediate must be on Din during T1; next T0.
REQ-014 op 010 add / 011 sub: T1 asserts controlReg[X], Ain -> T2; T2 asserts controlReg[Y], Gin, AddSub=op[0] -> T3; T3 asserts Gout, Rin[X], Done -> T0.
REQ-015 Undefined opcodes (and 100 without MVNZ_EN): T1 asserts Done only, no source, no load; next T0.
REQ-016 Control outputs SHALL be combinational decode of registered state and IR; no output latency beyond state.
REQ-017 At most one of controlReg[7:0], Gout, Din_out SHALL be high in any cycle; none high in T0.
REQ-018 At most one Rin bit SHALL be high in any cycle; Rin=0 in T0, T2.
REQ-019 X=Y is legal (mv R3,R3; add R3,R3); same sequence applies.
REQ-020 Run asserted in T1..T3 SHALL be ignored; Run held high SHALL start a new instruction on the cycle after Done.
REQ-021 Done SHALL pulse exactly one cycle per instruction.

Reset
REQ-022 Reset=1 at an edge SHALL force state T0 and IR=9'h000, overriding Run and any in-flight instruction.
REQ-023 During and after reset, all outputs SHALL be 0 until Run is accepted; no partial write-back (Rin) after an aborted add/sub.

Configuration
REQ-024 Macro UNIDADE_CONTROLE_MVNZ_EN SHALL enable op 100 mvnz: in T1, if Gnz=1 assert controlReg[Y] and Rin[X]; always assert Done; next T0.
REQ-025 Without UNIDADE_CONTROLE_MVNZ_EN, op 100 SHALL behave per REQ-015 and Gnz SHALL be ignored (port retained).

Structure
REQ-026 Package controle_pkg SHALL hold opcode constants (MV, MVI, ADD, SUB, MVNZ), state encoding, and IR field widths.
REQ-027 A 3-to-8 one-hot decoder sub-module dec3to8 (input 3, enable 1, output 8) SHALL generate Rin and controlReg from X/Y fields.

Verification
REQ-028 Reset, then Run=1, Din=16'h0005 (mv R0,R5) -> T1: controlReg=8'h20, Rin=8'h01, Done=1; back to T0 next cycle.
REQ-029 Din=16'h0048 (mvi R1) then Din=16'h1234 in T1 -> Din_out=1, Rin=8'h02, Done=1, controlReg=0.
REQ-030 Din=16'h00D3 (sub R2,R3) -> T1 controlReg=8'h04,Ain=1; T2 controlReg=8'h08,Gin=1,AddSub=1; T3 Gout=1,Rin=8'h04,Done=1.
REQ-031 add started, Reset=1 in T2 -> next cycle T0, Rin=0, Gout=0, Done never asserted for that instruction.
REQ-032 Din=16'h0101 (op 100, R0<-R1) with Gnz=0 then Gnz=1 -> MVNZ_EN: Rin=0 then Rin=8'h01; without macro: Done only both times.
REQ-033 Every cycle of random instruction stream: assertion of REQ-017/018 one-hot rules and single-cycle Done.
